// File: rtl/store.sv
// RV32I store unit: forms the effective address, lane-aligns the store data and
// issues one valid/ready write to data memory, reporting completion or an error.
module store #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        store_enable,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_value,
  input  logic [31:0] rs2_value,
  input  logic [31:0] immediate12,
  output logic [31:0] memory_write_address,
  output logic [31:0] memory_write_data,
  output logic [3:0]  memory_write_strobe,
  output logic        memory_write_valid,
  input  logic        memory_write_ready,
  output logic        store_busy,
  output logic        store_done,
  output logic        store_error,
  output logic [1:0]  store_error_code
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [2:0] F3_SB = 3'h0;
  localparam logic [2:0] F3_SH = 3'h1;
  localparam logic [2:0] F3_SW = 3'h2;

  localparam logic [1:0] ERR_MISALIGNED = 2'b01;
  localparam logic [1:0] ERR_FUNCT3     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b11;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  wait_count;
  logic [31:0] ea;
  logic [1:0]  off;
  logic [3:0]  lane_strobe;
  logic [31:0] lane_data;
  logic        illegal_funct3;
  logic        misaligned;

  assign ea         = rs1_value + immediate12;
  assign off        = ea[1:0];
  assign store_busy = (state != S_IDLE);

  always_comb begin
    lane_strobe    = 4'b0000;
    lane_data      = rs2_value;
    illegal_funct3 = 1'b0;
    misaligned     = 1'b0;
    case (funct3)
      F3_SB: begin
        lane_strobe = 4'b0001 << off;
        lane_data   = {4{rs2_value[7:0]}};
      end
      F3_SH: begin
        lane_strobe = 4'b0011 << off;
        lane_data   = {2{rs2_value[15:0]}};
        misaligned  = off[0];
      end
      F3_SW: begin
        lane_strobe = 4'b1111;
        lane_data   = rs2_value;
        misaligned  = (off != 2'b00);
      end
      default: illegal_funct3 = 1'b1;
    endcase
  end

  // Handshake: memory_write_valid rises with the request and stays high, with
  // address/data/strobe frozen, until the first edge where memory_write_ready
  // is also high; that edge is the transfer and drops valid.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state                <= S_IDLE;
      wait_count           <= 8'd0;
      memory_write_address <= 32'd0;
      memory_write_data    <= 32'd0;
      memory_write_strobe  <= 4'd0;
      memory_write_valid   <= 1'b0;
      store_done           <= 1'b0;
      store_error          <= 1'b0;
      store_error_code     <= 2'b00;
    end else begin
      store_done       <= 1'b0;
      store_error      <= 1'b0;
      store_error_code <= 2'b00;
      case (state)
        S_IDLE: begin
          if (store_enable) begin
            if (illegal_funct3) begin
              state            <= S_ERR;
              store_error      <= 1'b1;
              store_error_code <= ERR_FUNCT3;
            end else if (misaligned) begin
              state            <= S_ERR;
              store_error      <= 1'b1;
              store_error_code <= ERR_MISALIGNED;
            end else begin
              state                <= S_REQ;
              wait_count           <= 8'd0;
              memory_write_address <= {ea[31:2], 2'b00};
              memory_write_data    <= lane_data;
              memory_write_strobe  <= lane_strobe;
              memory_write_valid   <= 1'b1;
            end
          end
        end
        S_REQ: begin
          // Ready is checked first so a transfer on the expiring edge still completes.
          if (memory_write_ready) begin
            memory_write_valid <= 1'b0;
            state              <= S_DONE;
            store_done         <= 1'b1;
          end else if (wait_count == WAIT_LAST) begin
            memory_write_valid <= 1'b0;
            state              <= S_ERR;
            store_error        <= 1'b1;
            store_error_code   <= ERR_TIMEOUT;
          end else begin
            wait_count <= wait_count + 8'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store.sv
// Testbench for store: a reference model pushes the expected request or error
// code per store; a negedge monitor checks the memory port and status pulses.
module tb_store;

  localparam int TIMEOUT = 16;

  logic        clock;
  logic        reset_n;
  logic        store_enable;
  logic [2:0]  funct3;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic [31:0] immediate12;
  logic [31:0] memory_write_address;
  logic [31:0] memory_write_data;
  logic [3:0]  memory_write_strobe;
  logic        memory_write_valid;
  logic        memory_write_ready;
  logic        store_busy;
  logic        store_done;
  logic        store_error;
  logic [1:0]  store_error_code;

  store #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .store_enable         (store_enable),
    .funct3               (funct3),
    .rs1_value            (rs1_value),
    .rs2_value            (rs2_value),
    .immediate12          (immediate12),
    .memory_write_address (memory_write_address),
    .memory_write_data    (memory_write_data),
    .memory_write_strobe  (memory_write_strobe),
    .memory_write_valid   (memory_write_valid),
    .memory_write_ready   (memory_write_ready),
    .store_busy           (store_busy),
    .store_done           (store_done),
    .store_error          (store_error),
    .store_error_code     (store_error_code)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int valid_cycles = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  // entry: {error_code[1:0], address[31:0], data[31:0], strobe[3:0]}
  logic [69:0] exp_q[$];
  logic [69:0] mon_e;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [69:0] model(input logic [2:0] f3, input logic [31:0] rs1,
                                        input logic [31:0] rs2, input logic [31:0] imm);
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  c;
    a = rs1 + imm;
    c = 2'b00;
    d = 32'd0;
    s = 4'd0;
    if (f3 > 3'd2) c = 2'b10;
    else if (f3 == 3'd1 && a[0]) c = 2'b01;
    else if (f3 == 3'd2 && a[1:0] != 2'b00) c = 2'b01;
    if (f3 == 3'd0) begin
      d = {rs2[7:0], rs2[7:0], rs2[7:0], rs2[7:0]};
      case (a[1:0])
        2'd0: s = 4'b0001;
        2'd1: s = 4'b0010;
        2'd2: s = 4'b0100;
        default: s = 4'b1000;
      endcase
    end else if (f3 == 3'd1) begin
      d = {rs2[15:0], rs2[15:0]};
      s = a[1] ? 4'b1100 : 4'b0011;
    end else begin
      d = rs2;
      s = 4'b1111;
    end
    return {c, a[31:2], 2'b00, d, s};
  endfunction

  // monitor: checks every valid cycle against the head entry (also proves stability)
  always @(negedge clock) begin
    if (reset_n) begin
      if (memory_write_valid) begin
        valid_cycles++;
        if (exp_q.size() == 0) begin
          check_val("unexpected_valid", 32'(memory_write_valid), 32'd0);
        end else begin
          mon_e = exp_q[0];
          if (mon_e[69:68] == 2'b01 || mon_e[69:68] == 2'b10) begin
            check_val("valid_on_error", 32'(memory_write_valid), 32'd0);
          end else begin
            check_val("address", memory_write_address, mon_e[67:36]);
            check_val("data", memory_write_data, mon_e[35:4]);
            check_val("strobe", 32'(memory_write_strobe), 32'(mon_e[3:0]));
          end
          if (memory_write_ready) void'(exp_q.pop_front());
        end
      end
      if (store_error) begin
        err_cnt++;
        if (exp_q.size() == 0) begin
          check_val("unexpected_error", 32'(store_error), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("error_code", 32'(store_error_code), 32'(mon_e[69:68]));
        end
      end
      if (store_done) done_cnt++;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (store_busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check_val("idle_wait_expired", 32'(store_busy), 32'd0);
  endtask

  // delay = cycles ready stays low after the request; >= TIMEOUT means never ready
  task automatic run_store(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input int delay, input bit mid_pulse);
    logic [69:0] e;
    int d0;
    int e0;
    int n;
    int exp_valid;
    logic [1:0] code;
    wait_idle();
    e = model(f3, rs1, rs2, imm);
    code = e[69:68];
    if (code == 2'b00 && delay >= TIMEOUT) code = 2'b11;
    e[69:68] = code;
    exp_q.push_back(e);
    if (code == 2'b00) exp_valid = delay + 1;
    else if (code == 2'b11) exp_valid = TIMEOUT;
    else exp_valid = 0;
    @(negedge clock);
    d0 = done_cnt;
    e0 = err_cnt;
    valid_cycles = 0;
    funct3 = f3;
    rs1_value = rs1;
    rs2_value = rs2;
    immediate12 = imm;
    memory_write_ready = (delay == 0);
    store_enable = 1'b1;
    @(posedge clock);
    #1;
    store_enable = 1'b0;
    funct3 = 3'($urandom_range(0, 7));
    rs1_value = $urandom;
    rs2_value = $urandom;
    immediate12 = $urandom;
    if (delay > 0) begin
      for (int i = 0; i < delay && i < 24; i++) begin
        store_enable = mid_pulse && (i == 0);
        @(posedge clock);
        #1;
      end
      store_enable = 1'b0;
      if (delay < TIMEOUT) memory_write_ready = 1'b1;
    end
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40) check_val("completion_wait_expired", 32'(n), 32'd0);
    @(negedge clock);
    memory_write_ready = 1'b0;
    check_val("done_pulses", 32'(done_cnt - d0), 32'(code == 2'b00));
    check_val("error_pulses", 32'(err_cnt - e0), 32'(code != 2'b00));
    check_val("valid_cycles", 32'(valid_cycles), 32'(exp_valid));
    check_val("busy_after", 32'(store_busy), 32'd0);
  endtask

  initial begin
    int d0;
    int e0;
    reset_n = 1'b0;
    store_enable = 1'b0;
    funct3 = 3'd0;
    rs1_value = 32'd0;
    rs2_value = 32'd0;
    immediate12 = 32'd0;
    memory_write_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    check_val("reset_valid", 32'(memory_write_valid), 32'd0);
    check_val("reset_busy", 32'(store_busy), 32'd0);
    check_val("reset_done", 32'(store_done), 32'd0);
    check_val("reset_error", {29'd0, store_error, store_error_code}, 32'd0);
    check_val("reset_address", memory_write_address, 32'd0);
    check_val("reset_data", memory_write_data, 32'd0);
    check_val("reset_strobe", 32'(memory_write_strobe), 32'd0);

    run_store(3'd2, 32'h1000, 32'hDEADBEEF, 32'h8, 0, 1'b0);
    for (int i = 0; i < 4; i++) run_store(3'd0, 32'h2000, 32'hA5, 32'(i), 0, 1'b0);
    run_store(3'd1, 32'h3001, 32'h1234, 32'h0, 0, 1'b0);
    run_store(3'd1, 32'h3002, 32'h1234, 32'h0, 0, 1'b0);
    run_store(3'd2, 32'h4000, 32'h0BADF00D, 32'h10, 5, 1'b0);
    run_store(3'd2, 32'h4100, 32'h11223344, 32'h0, 20, 1'b0);
    run_store(3'd2, 32'h4200, 32'h55667788, 32'h4, 15, 1'b0);
    run_store(3'd3, 32'h1001, 32'h0, 32'h0, 0, 1'b0);
    run_store(3'd7, 32'h1002, 32'h0, 32'h0, 0, 1'b0);
    run_store(3'd2, 32'h5000, 32'hCAFEBABE, 32'h0, 3, 1'b1);
    run_store(3'd2, 32'hFFFFFFFC, 32'h89ABCDEF, 32'h4, 0, 1'b0);
    run_store(3'd1, 32'h6000, 32'hFFFF8001, 32'hFFFFFFFE, 0, 1'b0);

    for (int i = 0; i < 20; i++)
      run_store(3'($urandom_range(0, 3)), $urandom, $urandom, 32'($urandom_range(0, 15)),
                $urandom_range(0, 3), 1'b0);

    // reset while a request is waiting for ready
    wait_idle();
    exp_q.push_back(model(3'd2, 32'h7000, 32'h01020304, 32'h0));
    @(negedge clock);
    d0 = done_cnt;
    e0 = err_cnt;
    funct3 = 3'd2;
    rs1_value = 32'h7000;
    rs2_value = 32'h01020304;
    immediate12 = 32'h0;
    memory_write_ready = 1'b0;
    store_enable = 1'b1;
    @(posedge clock);
    #1;
    store_enable = 1'b0;
    @(negedge clock);
    check_val("req_valid_before_reset", 32'(memory_write_valid), 32'd1);
    reset_n = 1'b0;
    memory_write_ready = 1'b1;
    @(negedge clock);
    check_val("reset_mid_valid", 32'(memory_write_valid), 32'd0);
    check_val("reset_mid_busy", 32'(store_busy), 32'd0);
    check_val("reset_mid_done", 32'(store_done), 32'd0);
    reset_n = 1'b1;
    exp_q.delete();
    repeat (4) @(negedge clock);
    memory_write_ready = 1'b0;
    check_val("reset_mid_no_done", 32'(done_cnt - d0), 32'd0);
    check_val("reset_mid_no_error", 32'(err_cnt - e0), 32'd0);

    run_store(3'd0, 32'h8003, 32'h0000005A, 32'h0, 1, 1'b0);
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
